// File: rtl/riscv_serial_div_pkg.sv
// riscv_serial_div_pkg: shared types, widths and ALU divide operator encodings for the serial divider
package riscv_serial_div_pkg;
  typedef enum logic [1:0] {DIV_IDLE, DIV_DIVIDE, DIV_FINISH} div_state_t;
  localparam int DIV_WIDTH = 32;
  localparam int DIV_CNT_W = 5;
  localparam logic [6:0] ALU_DIVU = 7'b0110000;
  localparam logic [6:0] ALU_DIV  = 7'b0110001;
  localparam logic [6:0] ALU_REMU = 7'b0110010;
  localparam logic [6:0] ALU_REM  = 7'b0110011;
endpackage

// File: rtl/riscv_serial_div_if.sv
// riscv_serial_div_if: request/result handshake between the EX stage and the serial divider
interface riscv_serial_div_if;
  import riscv_serial_div_pkg::*;
  logic                 enable_i;
  logic [6:0]           operator_i;
  logic [DIV_WIDTH-1:0] op_a_i;
  logic [DIV_WIDTH-1:0] op_b_i;
  logic                 flush_i;
  logic                 ex_ready_i;
  logic                 ready_o;
  logic                 valid_o;
  logic [DIV_WIDTH-1:0] result_o;
  modport master (output enable_i, operator_i, op_a_i, op_b_i, flush_i, ex_ready_i,
                  input ready_o, valid_o, result_o);
  modport slave (input enable_i, operator_i, op_a_i, op_b_i, flush_i, ex_ready_i,
                 output ready_o, valid_o, result_o);
endinterface

// File: rtl/riscv_div_step.sv
// riscv_div_step: one restoring division step (shift in dividend MSB, compare, conditional subtract)
module riscv_div_step
  import riscv_serial_div_pkg::*;
(
  input  logic [DIV_WIDTH-1:0] rem,
  input  logic                 msb,
  input  logic [DIV_WIDTH-1:0] divisor,
  output logic [DIV_WIDTH-1:0] rem_n,
  output logic                 q
);
  logic [DIV_WIDTH-1:0] sh;
  logic [DIV_WIDTH:0]   diff;
  assign sh   = {rem[DIV_WIDTH-2:0], msb};
  assign diff = {1'b0, sh} - {1'b0, divisor};
  // a set rem MSB means the shifted value exceeds any 32-bit divisor
  assign q     = rem[DIV_WIDTH-1] | ~diff[DIV_WIDTH];
  assign rem_n = q ? diff[DIV_WIDTH-1:0] : sh;
endmodule

// File: rtl/riscv_serial_div.sv
// riscv_serial_div: iterative 32-bit DIV/DIVU/REM/REMU, one quotient bit per cycle
// Optional RISCV_DIV_EARLY_OUT_EN skips the iteration for b==0 or |a|<|b|.
module riscv_serial_div
  import riscv_serial_div_pkg::*;
(
  input logic               clk,
  input logic               rst,
  riscv_serial_div_if.slave bus
);
  div_state_t state, state_n;
  logic [1:0] op;
  logic [DIV_WIDTH-1:0] dividend, divisor, rem, rem_n, abs_a, abs_b, quo, rmd;
  logic [DIV_CNT_W-1:0] cnt;
  logic neg_q, neg_r, q_bit, sgn, b_zero, early, start;
  assign sgn    = bus.operator_i[0];
  assign abs_a  = (sgn && bus.op_a_i[DIV_WIDTH-1]) ? -bus.op_a_i : bus.op_a_i;
  assign abs_b  = (sgn && bus.op_b_i[DIV_WIDTH-1]) ? -bus.op_b_i : bus.op_b_i;
  assign b_zero = bus.op_b_i == '0;
`ifdef RISCV_DIV_EARLY_OUT_EN
  assign early = b_zero || abs_a < abs_b;
`else
  assign early = 1'b0;
`endif
  assign start = state == DIV_IDLE && bus.enable_i && !bus.flush_i;
  riscv_div_step u_step (
    .rem     (rem),
    .msb     (dividend[DIV_WIDTH-1]),
    .divisor (divisor),
    .rem_n   (rem_n),
    .q       (q_bit)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= DIV_IDLE;
    else     state <= state_n;
  always_comb begin
    state_n = bus.flush_i           ? DIV_IDLE :
              state == DIV_IDLE     ? (bus.enable_i ? (early ? DIV_FINISH : DIV_DIVIDE) : DIV_IDLE) :
              state == DIV_DIVIDE   ? (cnt == '0 ? DIV_FINISH : DIV_DIVIDE) :
              bus.ex_ready_i        ? DIV_IDLE : DIV_FINISH;
  end
  // quotient bits shift into the dividend register as its bits are consumed
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      op       <= '0;
      dividend <= '0;
      divisor  <= '0;
      rem      <= '0;
      cnt      <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
    end else if (start) begin
      op       <= bus.operator_i[1:0];
      dividend <= early ? (b_zero ? '1 : '0) : abs_a;
      divisor  <= abs_b;
      rem      <= early ? abs_a : '0;
      cnt      <= '1;
      neg_q    <= sgn && (bus.op_a_i[DIV_WIDTH-1] ^ bus.op_b_i[DIV_WIDTH-1]) && !b_zero;
      neg_r    <= sgn && bus.op_a_i[DIV_WIDTH-1];
    end else if (state == DIV_DIVIDE) begin
      dividend <= {dividend[DIV_WIDTH-2:0], q_bit};
      rem      <= rem_n;
      cnt      <= cnt - 1'b1;
    end
  assign quo          = neg_q ? -dividend : dividend;
  assign rmd          = neg_r ? -rem : rem;
  assign bus.result_o = op[1] ? rmd : quo;
  assign bus.ready_o  = state == DIV_IDLE;
  assign bus.valid_o  = state == DIV_FINISH;
endmodule

// File: tb/tb_riscv_serial_div.sv
// tb_riscv_serial_div: directed and randomized checks of riscv_serial_div against an arithmetic model
module tb_riscv_serial_div;
  import riscv_serial_div_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  riscv_serial_div_if bus ();
  riscv_serial_div dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_res(input logic [6:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q, r;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'd0;
    end else if (op[0]) begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      r = a % b;
    end
    return op[1] ? r : q;
  endfunction

  function automatic int ref_lat(input logic [6:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] ma, mb;
    ma = (op[0] && a[31]) ? -a : a;
    mb = (op[0] && b[31]) ? -b : b;
`ifdef RISCV_DIV_EARLY_OUT_EN
    return (b == 32'd0 || ma < mb) ? 1 : 33;
`else
    return (ma == mb) ? 33 : 33;
`endif
  endfunction

  task automatic wait_ready();
    for (int i = 0; i < 50 && !bus.ready_o; i++) begin
      @(posedge clk); #1;
    end
    check("ready_wait", {31'd0, bus.ready_o}, 32'd1);
  endtask

  task automatic run_op(input string tag, input logic [6:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int hold);
    int lat;
    logic [31:0] exp;
    exp = ref_res(op, a, b);
    wait_ready();
    bus.enable_i = 1'b1;
    bus.operator_i = op;
    bus.op_a_i = a;
    bus.op_b_i = b;
    @(posedge clk); #1;
    bus.enable_i = 1'b0;
    bus.op_a_i = $urandom;
    bus.op_b_i = $urandom;
    lat = 1;
    while (!bus.valid_o && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_lat"}, lat, ref_lat(op, a, b));
    check({tag, "_res"}, bus.result_o, exp);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({tag, "_hold"}, {bus.valid_o, bus.ready_o, bus.result_o}, {2'b10, exp});
    end
    bus.ex_ready_i = 1'b1;
    @(posedge clk); #1;
    bus.ex_ready_i = 1'b0;
    check({tag, "_done"}, {bus.ready_o, bus.valid_o}, 2'b10);
  endtask

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(0, 4))
      0: return $urandom;
      1: return $urandom_range(0, 300) - 150;
      2: return 32'd0;
      3: case ($urandom_range(0, 3))
           0: return 32'h8000_0000;
           1: return 32'hFFFF_FFFF;
           2: return 32'h7FFF_FFFF;
           default: return 32'd1;
         endcase
      default: return $urandom >> $urandom_range(0, 31);
    endcase
  endfunction

  initial begin
    logic [6:0] ops [4];
    int seen;
    ops = '{ALU_DIVU, ALU_DIV, ALU_REMU, ALU_REM};
    bus.enable_i = 1'b0;
    bus.operator_i = ALU_DIVU;
    bus.op_a_i = '0;
    bus.op_b_i = '0;
    bus.flush_i = 1'b0;
    bus.ex_ready_i = 1'b0;
    #22;
    check("rst_state", {bus.ready_o, bus.valid_o, bus.result_o}, {2'b10, 32'd0});
    @(posedge clk); #1;
    rst = 1'b0;
    run_op("divu_100_7", ALU_DIVU, 32'd100, 32'd7, 0);
    run_op("remu_100_7", ALU_REMU, 32'd100, 32'd7, 0);
    run_op("div_m7_2", ALU_DIV, -32'sd7, 32'd2, 0);
    run_op("rem_m7_2", ALU_REM, -32'sd7, 32'd2, 0);
    run_op("rem_7_m2", ALU_REM, 32'd7, -32'sd2, 0);
    run_op("div_5_0", ALU_DIV, 32'd5, 32'd0, 0);
    run_op("rem_5_0", ALU_REM, 32'd5, 32'd0, 0);
    run_op("divu_max_0", ALU_DIVU, 32'hFFFF_FFFF, 32'd0, 0);
    run_op("rem_m5_0", ALU_REM, -32'sd5, 32'd0, 0);
    run_op("div_ovf", ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op("rem_ovf", ALU_REM, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op("divu_big", ALU_DIVU, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0);
    run_op("remu_big", ALU_REMU, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 0);
    run_op("hold5", ALU_DIV, 32'd1000, -32'sd33, 5);
    run_op("b2b", ALU_REMU, 32'd12345, 32'd100, 0);
    // flush in the 10th DIVIDE cycle with a competing request
    wait_ready();
    bus.enable_i = 1'b1;
    bus.operator_i = ALU_DIVU;
    bus.op_a_i = 32'd1000;
    bus.op_b_i = 32'd3;
    @(posedge clk); #1;
    bus.enable_i = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    bus.flush_i = 1'b1;
    bus.enable_i = 1'b1;
    bus.op_a_i = 32'd77;
    bus.op_b_i = 32'd0;
    @(posedge clk); #1;
    bus.flush_i = 1'b0;
    bus.enable_i = 1'b0;
    check("flush_idle", {bus.ready_o, bus.valid_o}, 2'b10);
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.valid_o || !bus.ready_o) seen++;
    end
    check("flush_quiet", seen, 0);
    run_op("after_flush", ALU_DIVU, 32'd9, 32'd3, 0);
    // flush while the result waits drops it even with ex_ready_i high
    wait_ready();
    bus.enable_i = 1'b1;
    bus.operator_i = ALU_DIV;
    bus.op_a_i = 32'd500;
    bus.op_b_i = 32'd7;
    @(posedge clk); #1;
    bus.enable_i = 1'b0;
    repeat (34) begin @(posedge clk); #1; end
    check("fin_wait", {bus.ready_o, bus.valid_o}, 2'b01);
    bus.flush_i = 1'b1;
    bus.ex_ready_i = 1'b1;
    @(posedge clk); #1;
    bus.flush_i = 1'b0;
    bus.ex_ready_i = 1'b0;
    check("fin_flush", {bus.ready_o, bus.valid_o}, 2'b10);
    // asynchronous reset in the middle of an iteration
    wait_ready();
    bus.enable_i = 1'b1;
    bus.operator_i = ALU_REM;
    bus.op_a_i = 32'hDEAD_BEEF;
    bus.op_b_i = 32'd13;
    @(posedge clk); #1;
    bus.enable_i = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    #2 rst = 1'b1;
    #1;
    check("async_rst", {bus.ready_o, bus.valid_o, bus.result_o}, {2'b10, 32'd0});
    @(posedge clk); #1;
    rst = 1'b0;
    run_op("after_rst", ALU_DIVU, 32'd9, 32'd3, 0);
    for (int n = 0; n < 150; n++)
      run_op("rnd", ops[$urandom_range(0, 3)], rnd_operand(), rnd_operand(), $urandom_range(0, 2));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
